// File: rtl/uart_fifo_model_pkg.sv
// Shared constants for the FIFO-buffered simulation UART: register offsets,
// LSR bit positions, IIR codes and the TX shifter state type.
package uart_fifo_model_pkg;

    localparam logic [4:0] RBR_THR = 5'h00;
    localparam logic [4:0] IER     = 5'h04;
    localparam logic [4:0] IIR     = 5'h08;
    localparam logic [4:0] LSR     = 5'h14;
    localparam logic [4:0] TXLVL   = 5'h18;
    localparam logic [4:0] RXLVL   = 5'h1C;

    localparam int LSR_DR    = 0;
    localparam int LSR_OE    = 1;
    localparam int LSR_THRE  = 5;
    localparam int LSR_TEMT  = 6;
    localparam int LSR_TXOVF = 7;

    localparam logic [7:0] IIR_RX_DATA   = 8'h04;
    localparam logic [7:0] IIR_THR_EMPTY = 8'h02;
    localparam logic [7:0] IIR_NONE      = 8'h01;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } shift_state_e;

endpackage

// File: rtl/uart_fifo_model_if.sv
// Peripheral-bus, RX-injection and TX-monitor signals of the simulation UART.
// master = processor/bench side, slave = the UART.
interface uart_fifo_model_if;

    logic        cs;
    logic [4:0]  addr;
    logic        wr;
    logic [31:0] wdata;
    logic        rd;
    logic [31:0] rdata;
    logic        rvalid;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        irq;

    modport master (
        output cs, addr, wr, wdata, rd, rx_valid, rx_data,
        input  rdata, rvalid, rx_ready, tx_valid, tx_data, irq
    );

    modport slave (
        input  cs, addr, wr, wdata, rd, rx_valid, rx_data,
        output rdata, rvalid, rx_ready, tx_valid, tx_data, irq
    );

endinterface

// File: rtl/uart_fifo_model_fifo.sv
// Generic synchronous FIFO with level output. A push while full is accepted
// only when a pop happens on the same edge.
module uart_fifo_model_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WIDTH-1:0]             din,
    output logic [WIDTH-1:0]             dout,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   level
);

    localparam int LW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    assign dout  = mem[rd_ptr];
    assign full  = (level == LW'(DEPTH));
    assign empty = (level == '0);

endmodule

// File: rtl/uart_fifo_model.sv
// FIFO-buffered memory-mapped simulation UART. Define UART_FIFO_MODEL_IRQ_EN
// to enable the IER/IIR registers and the irq output.
//
// state    | meaning
// ST_IDLE  | no character in flight
// ST_SHIFT | character held in shreg_q, down-counting CHAR_CYCLES
module uart_fifo_model #(
    parameter int TX_DEPTH    = 16,
    parameter int RX_DEPTH    = 16,
    parameter int CHAR_CYCLES = 8
) (
    input  logic               clk,
    input  logic               reset,
    uart_fifo_model_if.slave   bus
);

    import uart_fifo_model_pkg::*;

    localparam int TLW = $clog2(TX_DEPTH + 1);
    localparam int RLW = $clog2(RX_DEPTH + 1);
    localparam int CW  = (CHAR_CYCLES > 1) ? $clog2(CHAR_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(CHAR_CYCLES - 1);

    logic           rd_acc, wr_acc, thr_wr, rbr_rd, lsr_rd;
    logic           tx_pop, tx_full, tx_empty, tx_drop;
    logic [7:0]     tx_head;
    logic [TLW-1:0] tx_level;
    logic           rx_push, rx_full, rx_empty, rx_drop;
    logic [7:0]     rx_head;
    logic [RLW-1:0] rx_level;

    shift_state_e   state_q, state_d;
    logic [CW-1:0]  cnt_q;
    logic [7:0]     shreg_q;
    logic           tc, fire;

    logic           rvalid_q, tx_valid_q, rx_ready_q, irq_q, irq_d;
    logic [31:0]    rdata_q, rd_mux;
    logic [7:0]     tx_data_q, lsr_val, iir_code;
    logic           oe_q, txovf_q;
    logic [1:0]     ier_q;
    logic           unused_wdata;

    assign rd_acc  = bus.cs & bus.rd & ~rvalid_q;
    assign wr_acc  = bus.cs & bus.wr;
    assign thr_wr  = wr_acc & (bus.addr == RBR_THR);
    assign rbr_rd  = rd_acc & (bus.addr == RBR_THR);
    assign lsr_rd  = rd_acc & (bus.addr == LSR);
    assign tx_drop = thr_wr & tx_full & ~tx_pop;
    assign rx_push = bus.rx_valid & ~rx_full;
    assign rx_drop = bus.rx_valid & rx_full;
    assign unused_wdata = ^bus.wdata[31:8];

    uart_fifo_model_fifo #(.DEPTH(TX_DEPTH), .WIDTH(8)) u_tx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (thr_wr),
        .pop   (tx_pop),
        .din   (bus.wdata[7:0]),
        .dout  (tx_head),
        .full  (tx_full),
        .empty (tx_empty),
        .level (tx_level)
    );

    uart_fifo_model_fifo #(.DEPTH(RX_DEPTH), .WIDTH(8)) u_rx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (rx_push),
        .pop   (rbr_rd),
        .din   (bus.rx_data),
        .dout  (rx_head),
        .full  (rx_full),
        .empty (rx_empty),
        .level (rx_level)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    assign tc = (cnt_q == '0);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (!tx_empty)      state_d = ST_SHIFT;
            ST_SHIFT: if (tc && tx_empty) state_d = ST_IDLE;
            default:                      state_d = ST_IDLE;
        endcase
    end

    // Back-to-back characters: the terminal count of one pops the next.
    always_comb begin
        fire   = 1'b0;
        tx_pop = 1'b0;
        case (state_q)
            ST_IDLE:  tx_pop = ~tx_empty;
            ST_SHIFT: begin
                fire   = tc;
                tx_pop = tc & ~tx_empty;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q      <= '0;
            shreg_q    <= '0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
        end else begin
            tx_valid_q <= fire;
            if (fire) tx_data_q <= shreg_q;
            if (tx_pop) begin
                cnt_q   <= CNT_LOAD;
                shreg_q <= tx_head;
            end else if (!tc) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!reset && fire) $write("%c", shreg_q);
    end
`endif

`ifdef UART_FIFO_MODEL_IRQ_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                           ier_q <= 2'b00;
        else if (wr_acc && bus.addr == IER)  ier_q <= bus.wdata[1:0];
    end
    assign iir_code = !rx_empty ? IIR_RX_DATA : (tx_empty ? IIR_THR_EMPTY : IIR_NONE);
    assign irq_d    = (ier_q[0] & ~rx_empty) | (ier_q[1] & tx_empty);
`else
    assign ier_q    = 2'b00;
    assign iir_code = IIR_NONE;
    assign irq_d    = 1'b0;
`endif

    always_comb begin
        lsr_val            = '0;
        lsr_val[LSR_DR]    = ~rx_empty;
        lsr_val[LSR_OE]    = oe_q;
        lsr_val[LSR_THRE]  = tx_empty;
        lsr_val[LSR_TEMT]  = tx_empty & (state_q == ST_IDLE);
        lsr_val[LSR_TXOVF] = txovf_q;
    end

    always_comb begin
        rd_mux = '0;
        case (bus.addr)
            RBR_THR: rd_mux = {24'b0, (rx_empty ? 8'h00 : rx_head)};
            IER:     rd_mux = {30'b0, ier_q};
            IIR:     rd_mux = {24'b0, iir_code};
            LSR:     rd_mux = {24'b0, lsr_val};
            TXLVL:   rd_mux = 32'(tx_level);
            RXLVL:   rd_mux = 32'(rx_level);
            default: rd_mux = '0;
        endcase
    end

    // A new overflow on the same edge as an LSR read stays visible.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            oe_q       <= 1'b0;
            txovf_q    <= 1'b0;
            rx_ready_q <= 1'b1;
            irq_q      <= 1'b0;
        end else begin
            rvalid_q <= rd_acc;
            if (rd_acc) rdata_q <= rd_mux;
            if (lsr_rd) begin
                oe_q    <= 1'b0;
                txovf_q <= 1'b0;
            end
            if (rx_drop) oe_q    <= 1'b1;
            if (tx_drop) txovf_q <= 1'b1;
            rx_ready_q <= ~rx_full;
            irq_q      <= irq_d;
        end
    end

    assign bus.rdata    = rdata_q;
    assign bus.rvalid   = rvalid_q;
    assign bus.tx_valid = tx_valid_q;
    assign bus.tx_data  = tx_data_q;
    assign bus.rx_ready = rx_ready_q;
    assign bus.irq      = irq_q;

endmodule

// File: tb/tb_uart_fifo_model.sv
// Self-checking bench for uart_fifo_model: directed scenarios plus random
// traffic, all outputs compared every cycle against a queue-based model.
module tb_uart_fifo_model;

    localparam int TXD = 4;
    localparam int RXD = 4;
    localparam int CC  = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;

    uart_fifo_model_if bus_if();

    uart_fifo_model #(.TX_DEPTH(TXD), .RX_DEPTH(RXD), .CHAR_CYCLES(CC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if.slave)
    );

    always #5 clk = ~clk;

    byte unsigned txq[$];
    byte unsigned rxq[$];
    bit          m_busy;
    int          m_remain;
    logic [7:0]  m_cur;
    bit          m_oe, m_txovf;
    logic [1:0]  m_ier;
    logic        m_rvalid, m_txv, m_irq, m_rxready;
    logic [31:0] m_rdata;
    logic [7:0]  m_txd;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    logic [15:0] tx_hist  = '0;
    int          tx_cycles[$];
    logic [31:0] d;
    int          e;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        txq.delete();
        rxq.delete();
        m_busy = 0; m_remain = 0; m_cur = '0;
        m_oe = 0; m_txovf = 0; m_ier = '0;
        m_rvalid = 0; m_rdata = '0; m_txv = 0; m_txd = '0;
        m_irq = 0; m_rxready = 1;
    endtask

    // One clock edge of the UART, computed from the state before the edge.
    task automatic model_step();
        int txn = txq.size();
        int rxn = rxq.size();
        bit rd_acc, fire, pop_tx, wr_thr;
        logic [31:0] rv;
        rd_acc = bus_if.cs && bus_if.rd && !m_rvalid;
        rv = 0;
        case (bus_if.addr)
            5'h00: rv = (rxn > 0) ? 32'(rxq[0]) : 32'h0;
            5'h04: rv = 32'(m_ier);
`ifdef UART_FIFO_MODEL_IRQ_EN
            5'h08: rv = (rxn > 0) ? 32'h4 : ((txn == 0) ? 32'h2 : 32'h1);
`else
            5'h08: rv = 32'h1;
`endif
            5'h14: rv = 32'((rxn > 0) ? 1 : 0) + (m_oe ? 32'h2 : 32'h0)
                        + ((txn == 0) ? 32'h20 : 32'h0)
                        + ((txn == 0 && !m_busy) ? 32'h40 : 32'h0)
                        + (m_txovf ? 32'h80 : 32'h0);
            5'h18: rv = 32'(txn);
            5'h1C: rv = 32'(rxn);
            default: rv = 0;
        endcase
        m_rvalid = rd_acc;
        if (rd_acc) m_rdata = rv;
        m_rxready = (rxn < RXD);
`ifdef UART_FIFO_MODEL_IRQ_EN
        m_irq = (m_ier[0] && rxn > 0) || (m_ier[1] && txn == 0);
`else
        m_irq = 0;
`endif
        fire   = m_busy && (m_remain == 0);
        pop_tx = (!m_busy || fire) && (txn > 0);
        m_txv  = fire;
        if (fire) m_txd = m_cur;
        if (pop_tx) begin
            m_cur = txq.pop_front();
            m_busy = 1;
            m_remain = CC - 1;
        end else if (fire) begin
            m_busy = 0;
        end else if (m_busy) begin
            m_remain--;
        end
        if (rd_acc && bus_if.addr == 5'h14) begin
            m_oe = 0;
            m_txovf = 0;
        end
        wr_thr = bus_if.cs && bus_if.wr && bus_if.addr == 5'h00;
        if (wr_thr) begin
            if (txn < TXD || pop_tx) txq.push_back(bus_if.wdata[7:0]);
            else m_txovf = 1;
        end
        if (rd_acc && bus_if.addr == 5'h00 && rxn > 0) void'(rxq.pop_front());
        if (bus_if.rx_valid) begin
            if (rxn < RXD) rxq.push_back(bus_if.rx_data);
            else m_oe = 1;
        end
`ifdef UART_FIFO_MODEL_IRQ_EN
        if (bus_if.cs && bus_if.wr && bus_if.addr == 5'h04) m_ier = bus_if.wdata[1:0];
`endif
    endtask

    task automatic tick();
        if (reset) model_reset();
        else model_step();
        @(posedge clk);
        #1;
        cyc++;
        if (bus_if.tx_valid === 1'b1) begin
            tx_hist = {tx_hist[7:0], bus_if.tx_data};
            tx_cycles.push_back(cyc);
        end
        check("rvalid",   32'(bus_if.rvalid),   32'(m_rvalid));
        check("rdata",    bus_if.rdata,         m_rdata);
        check("tx_valid", 32'(bus_if.tx_valid), 32'(m_txv));
        check("tx_data",  32'(bus_if.tx_data),  32'(m_txd));
        check("irq",      32'(bus_if.irq),      32'(m_irq));
        check("rx_ready", 32'(bus_if.rx_ready), 32'(m_rxready));
    endtask

    task automatic idle();
        bus_if.cs = 0; bus_if.rd = 0; bus_if.wr = 0; bus_if.addr = '0;
        bus_if.wdata = '0; bus_if.rx_valid = 0; bus_if.rx_data = '0;
    endtask

    task automatic bus_write(input logic [4:0] a, input logic [31:0] v);
        bus_if.cs = 1; bus_if.wr = 1; bus_if.addr = a; bus_if.wdata = v;
        tick();
        idle();
    endtask

    task automatic bus_read(input logic [4:0] a, output logic [31:0] v);
        bus_if.cs = 1; bus_if.rd = 1; bus_if.addr = a;
        tick();
        idle();
        check("read_rvalid", 32'(bus_if.rvalid), 32'h1);
        v = bus_if.rdata;
        tick();
    endtask

    task automatic rx_inject(input logic [7:0] c);
        bus_if.rx_valid = 1; bus_if.rx_data = c;
        tick();
        idle();
    endtask

    task automatic wait_drain();
        int k = 0;
        while ((txq.size() != 0 || m_busy) && k < 400) begin
            tick();
            k++;
        end
        if (k >= 400) check("drain_timeout", 32'(k), 32'h0);
        tick();
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0] addrs [8];
        addrs = '{5'h00, 5'h04, 5'h08, 5'h14, 5'h18, 5'h1C, 5'h0C, 5'h10};
        idle();
        reset = 1;
        model_reset();
        tick();
        tick();
        reset = 0;
        tick();
        check("rst_irq",      32'(bus_if.irq),      32'h0);
        check("rst_rx_ready", 32'(bus_if.rx_ready), 32'h1);
        check("rst_tx_valid", 32'(bus_if.tx_valid), 32'h0);
        bus_read(5'h14, d);
        check("rst_lsr", d, 32'h60);

        // "Hi": first tx_valid CHAR_CYCLES+1 edges after the write
        tx_cycles.delete();
        bus_write(5'h00, 32'h48);
        e = cyc;
        bus_write(5'h00, 32'h69);
        for (int k = 0; k < 40 && tx_cycles.size() < 2; k++) tick();
        if (tx_cycles.size() < 2) begin
            check("hi_timeout", 32'(tx_cycles.size()), 32'h2);
        end else begin
            check("hi_first_cycle",  32'(tx_cycles[0]), 32'(e + CC + 1));
            check("hi_second_cycle", 32'(tx_cycles[1]), 32'(e + 2 * CC + 1));
            check("hi_chars", 32'(tx_hist), 32'h4869);
        end
        wait_drain();
        bus_read(5'h18, d);
        check("hi_txlvl", d, 32'h0);
        bus_read(5'h14, d);
        check("hi_temt", d & 32'h40, 32'h40);

        // TX overflow: 8 back-to-back writes into a 4-deep FIFO
        for (int k = 0; k < 8; k++) bus_write(5'h00, 32'(8'h41 + k));
        bus_read(5'h18, d);
        check("ovf_txlvl", d, 32'h4);
        bus_read(5'h14, d);
        check("ovf_txovf_set", (d >> 7) & 32'h1, 32'h1);
        bus_read(5'h14, d);
        check("ovf_txovf_clr", (d >> 7) & 32'h1, 32'h0);
        wait_drain();

        // RX basic
        rx_inject(8'h41);
        rx_inject(8'h42);
        bus_read(5'h14, d);
        check("rx_dr_set", d & 32'h1, 32'h1);
        bus_read(5'h1C, d);
        check("rx_level2", d, 32'h2);
        bus_read(5'h00, d);
        check("rx_first", d, 32'h41);
        bus_read(5'h00, d);
        check("rx_second", d, 32'h42);
        bus_read(5'h14, d);
        check("rx_dr_clr", d & 32'h1, 32'h0);
        bus_read(5'h00, d);
        check("rx_empty_read", d, 32'h0);

        // RX overflow
        for (int k = 0; k < 5; k++) rx_inject(8'(8'h31 + k));
        check("rx_full_ready", 32'(bus_if.rx_ready), 32'h0);
        bus_read(5'h14, d);
        check("rx_oe_set", d & 32'h3, 32'h3);
        for (int k = 0; k < 4; k++) begin
            bus_read(5'h00, d);
            check("rx_fill_data", d, 32'(8'h31 + k));
        end
        bus_read(5'h00, d);
        check("rx_fifth_lost", d, 32'h0);

`ifdef UART_FIFO_MODEL_IRQ_EN
        bus_write(5'h04, 32'h1);
        rx_inject(8'h55);
        tick();
        check("irq_rx_rise", 32'(bus_if.irq), 32'h1);
        bus_read(5'h08, d);
        check("iir_rx", d, 32'h4);
        bus_read(5'h00, d);
        check("irq_rx_data", d, 32'h55);
        tick();
        check("irq_rx_fall", 32'(bus_if.irq), 32'h0);
        bus_write(5'h04, 32'h2);
        tick();
        tick();
        check("irq_thre", 32'(bus_if.irq), 32'h1);
        bus_read(5'h08, d);
        check("iir_thre", d, 32'h2);
        bus_write(5'h04, 32'h0);
`else
        bus_write(5'h04, 32'h3);
        rx_inject(8'h55);
        tick();
        check("irq_off", 32'(bus_if.irq), 32'h0);
        bus_read(5'h04, d);
        check("ier_off", d, 32'h0);
        bus_read(5'h08, d);
        check("iir_off", d, 32'h1);
        bus_read(5'h00, d);
        check("irq_off_data", d, 32'h55);
`endif

        // random traffic against the model
        for (int i = 0; i < 1500; i++) begin
            bus_if.cs = ($urandom_range(0, 99) < 70);
            bus_if.rd = $urandom_range(0, 1) == 1;
            bus_if.wr = $urandom_range(0, 2) == 0;
            bus_if.addr = ($urandom_range(0, 1) == 1) ? 5'h00 : addrs[$urandom_range(0, 7)];
            bus_if.wdata = {$urandom_range(0, 32'hFFFFFF) & 32'hFFFFFF, 8'h00}
                           | 32'(8'h41 + $urandom_range(0, 25));
            bus_if.rx_valid = $urandom_range(0, 2) == 0;
            bus_if.rx_data = 8'($urandom);
            tick();
        end
        idle();
        wait_drain();

        // reset in the middle of a character aborts it
        bus_write(5'h00, 32'h5A);
        tick();
        tick();
        reset = 1;
        #1;
        check("arst_tx_valid", 32'(bus_if.tx_valid), 32'h0);
        check("arst_tx_data",  32'(bus_if.tx_data),  32'h0);
        check("arst_rvalid",   32'(bus_if.rvalid),   32'h0);
        check("arst_rdata",    bus_if.rdata,         32'h0);
        check("arst_rx_ready", 32'(bus_if.rx_ready), 32'h1);
        check("arst_irq",      32'(bus_if.irq),      32'h0);
        model_reset();
        tick();
        tick();
        reset = 0;
        tx_cycles.delete();
        for (int k = 0; k < 3 * CC; k++) tick();
        check("arst_no_tx", 32'(tx_cycles.size()), 32'h0);
        bus_read(5'h18, d);
        check("arst_txlvl", d, 32'h0);

        $display("");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_fifo_model.md
# uart_fifo_model

Parametrised, FIFO-buffered successor to the console UART model: a memory-mapped simulation UART on the processor's peripheral bus. Written characters queue in a TX FIFO and drain at a configurable per-character rate to the simulator console and a monitor port. A bench-driven RX path queues characters in an RX FIFO for software to read. Status, level and optional interrupt registers let the RISC-V software poll or take interrupts.

## Interface
- TX_DEPTH, 16: TX FIFO entries; power of two, ≥2
- RX_DEPTH, 16: RX FIFO entries; power of two, ≥2
- CHAR_CYCLES, 8: clock cycles per drained character; ≥1
- clk  input  1  clock; all logic on rising edge
- reset  input  1  asynchronous, active-high reset
- cs  input  1  block select
- addr  input  5  byte register offset
- wr  input  1  write strobe; qualified by cs
- wdata  input  32  write data
- rd  input  1  read strobe; qualified by cs
- rdata  output  32  registered read data
- rvalid  output  1  one-cycle read-data-valid pulse
- rx_valid  input  1  bench presents an RX character
- rx_data  input  8  RX character
- rx_ready  output  1  RX FIFO not full
- tx_valid  output  1  one-cycle pulse per drained character
- tx_data  output  8  drained character, valid with tx_valid
- irq  output  1  level interrupt

## Operation
- Register map:
  - 0x00 write = THR push of wdata[7:0]; read = RBR pop.
  - 0x04 IER: bit0 RX-data enable, bit1 THR-empty enable.
  - 0x08 IIR, read-only: 0x04 RX data pending (priority); else 0x02 THR empty; else 0x01.
  - 0x14 LSR: bit0 DR (RX not empty), bit1 OE (sticky RX overflow), bit5 THRE (TX FIFO empty), bit6 TEMT (THRE and shifter idle), bit7 TXOVF (sticky TX drop).
  - 0x18 TX level; 0x1C RX level.
  - Other offsets read 0; writes ignored.
- Read accept: cs & rd & ~rvalid.
  - rdata loads on the accept edge.
  - RBR accept with RX non-empty pops the head. With RX empty, returns 0 and does not pop.
  - LSR accept returns the current value, then clears OE and TXOVF.
- THR write: accepted if TX level < TX_DEPTH, or if the shifter pops on the same edge. Otherwise the write is dropped and TXOVF is set.
- Shifter FSM, states IDLE and SHIFT:
  - IDLE & TX non-empty: pop head, load counter with CHAR_CYCLES-1, go to SHIFT.
  - SHIFT at counter 0: pulse tx_valid with tx_data and $write("%c") the character. If TX is non-empty, pop the next head on the same edge; otherwise go to IDLE.
- RX push: rx_valid & RX not full at the start of the cycle pushes rx_data. rx_valid while full drops the character and sets OE; a simultaneous RBR pop does not rescue it.
- Simultaneous push and pop on a non-empty FIFO: level unchanged.
- Push into an empty RX with a same-cycle RBR read: the read returns 0 and the push is kept.
- irq = (IER[0] & DR) | (IER[1] & THRE).
- Level and count widths are $clog2(DEPTH+1). Pointers wrap modulo DEPTH.

## Timing
- Reset values: rdata 0, rvalid 0, tx_valid 0, tx_data 0, irq 0, rx_ready 1. FIFOs empty, IER 0, sticky bits 0, FSM IDLE.
- Reset asserted mid-character aborts the character: no tx_valid and no $write. FIFO contents are lost.
- Read latency: rdata and rvalid are valid on the edge after the accept. Back-to-back reads alternate accept/ignore, so one read completes every 2 cycles.
- THR write at edge t into an empty TX with an idle shifter: pop at t+1, tx_valid at t+CHAR_CYCLES+1.
- Sustained drain: one character every CHAR_CYCLES cycles.
- irq and rx_ready are registered: they reflect state as of the previous edge.

## Configuration
- UART_FIFO_MODEL_IRQ_EN defined: IER is writable, IIR decodes as above, and irq is driven.
- Not defined: IER reads 0 and ignores writes, IIR reads 0x01, and irq is tied 0.
- All other behaviour is identical in both builds.

## Structure
- Package uart_fifo_model_pkg holds:
  - register offset constants (RBR_THR, IER, IIR, LSR, TXLVL, RXLVL);
  - LSR bit index constants;
  - IIR code constants;
  - the shifter state enum.
- Sub-module uart_fifo_model_fifo: generic synchronous FIFO with push, pop, full, empty and level, parametrised by DEPTH and WIDTH. It is instantiated twice, once for TX and once for RX.

## Test plan
- Reset, then read 0x14 → rdata 0x60 with rvalid high one cycle after the accept. irq is 0 and rx_ready is 1.
- CHAR_CYCLES=4: write 'H','i' to 0x00 on consecutive cycles → tx_valid carrying 0x48 four cycles after the first pop, then 0x69 four cycles later. Console shows "Hi". TX level then 0 and LSR bit6 = 1.
- TX_DEPTH=4, shifter stalled by a large CHAR_CYCLES: 6 writes → TX level reads 4 after the first pop completes and LSR bit7 = 1. A second LSR read shows bit7 = 0.
- Inject 0x41, 0x42 on rx_valid → LSR bit0 = 1 and RX level 2. RBR reads return 0x41 then 0x42, then LSR bit0 = 0. A further RBR read returns 0.
- Fill RX (RX_DEPTH=4) and inject a fifth character → rx_ready is 0, LSR bit1 = 1, and the fifth character is never read back.
- With UART_FIFO_MODEL_IRQ_EN: write IER=0x1 and inject 0x55 → irq rises and IIR = 0x04. Read RBR → irq falls. Write IER=0x2 → irq is 1 and IIR = 0x02.
